// File: rtl/rgb_matrix_pkg.sv
// Shared types, field positions and helpers for the RGB matrix capture path.
package rgb_matrix_pkg;

  localparam int ROWS      = 8;
  localparam int WORD_W    = 24;
  localparam int BIT_CNT_W = 5;

  localparam int RED_MSB = 23;
  localparam int RED_LSB = 16;
  localparam int GRN_MSB = 15;
  localparam int GRN_LSB = 8;
  localparam int BLU_MSB = 7;
  localparam int BLU_LSB = 0;

  typedef logic [7:0] row_t;
  typedef row_t [0:ROWS-1] plane_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
  } row_sel_t;

  // KATOT bit 7 selects row 0; anything other than exactly one set bit is invalid.
  function automatic row_sel_t onehot_to_row(input logic [7:0] sel);
    row_sel_t res;
    res.valid = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    res.row   = 3'd0;
    for (int i = 0; i < ROWS; i++) begin
      if (sel[i]) begin
        res.row = 3'(ROWS - 1 - i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// N-stage input synchroniser with rise/fall detection against a one-cycle-delayed copy.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~prev_reg;
  assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/rgb_matrix_capture.sv
// Rebuilds red/green/blue frames by snooping the 74HC595-style matrix driver pins.
module rgb_matrix_capture
  import rgb_matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DS,
  input  logic       SH_CP,
  input  logic       ST_CP,
  input  logic       MR_N,
  input  logic       OE,
  input  logic [7:0] KATOT,
  input  logic       err_clr,
  output plane_t     red,
  output plane_t     green,
  output plane_t     blue,
  output logic       row_valid,
  output logic [2:0] row_idx,
  output logic       frame_valid,
  output logic       len_err,
  output logic       katot_err,
  output logic       frame_err
);

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(WORD_W);

  // Pin front end
  logic sh_rise, st_rise, mr_level, oe_fall;
  logic sh_level_unused, sh_fall_unused;
  logic st_level_unused, st_fall_unused;
  logic mr_rise_unused, mr_fall_unused;
  logic oe_level_unused, oe_rise_unused;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sh (
    .clk(clk), .reset(reset), .din(SH_CP),
    .level(sh_level_unused), .rise(sh_rise), .fall(sh_fall_unused)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_st (
    .clk(clk), .reset(reset), .din(ST_CP),
    .level(st_level_unused), .rise(st_rise), .fall(st_fall_unused)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mr (
    .clk(clk), .reset(reset), .din(MR_N),
    .level(mr_level), .rise(mr_rise_unused), .fall(mr_fall_unused)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(clk), .reset(reset), .din(OE),
    .level(oe_level_unused), .rise(oe_rise_unused), .fall(oe_fall)
  );

  // DS and KATOT are level-sampled, aligned with the edge detectors above.
  logic [8:0] data_sync_reg [SYNC_STAGES];
  logic       ds_sync;
  logic [7:0] kat_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_reg[i] <= '0;
      end
    end else begin
      data_sync_reg[0] <= {DS, KATOT};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_reg[i] <= data_sync_reg[i-1];
      end
    end
  end

  assign ds_sync  = data_sync_reg[SYNC_STAGES-1][8];
  assign kat_sync = data_sync_reg[SYNC_STAGES-1][7:0];

  // Capture state
  logic [WORD_W-1:0]    shreg_reg, hold_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [ROWS-1:0]      row_mask_reg;
  plane_t               red_w_reg, green_w_reg, blue_w_reg;
  plane_t               red_reg, green_reg, blue_reg;
  logic                 row_valid_reg, frame_valid_reg;
  logic [2:0]           row_idx_reg;
  logic                 len_err_reg, katot_err_reg, frame_err_reg;

  // Commit decode
  row_sel_t        sel_info;
  logic            commit, bad_sel, last_row, publish, incomplete, len_bad;
  logic [ROWS-1:0] mask_next;
  plane_t          red_next, green_next, blue_next;

  always_comb begin
    sel_info   = onehot_to_row(kat_sync);
    commit     = oe_fall & sel_info.valid;
    bad_sel    = oe_fall & ~sel_info.valid;
    mask_next  = row_mask_reg | (ROWS'(1) << sel_info.row);
    last_row   = (sel_info.row == 3'(ROWS - 1));
    publish    = commit & last_row & (&mask_next);
    incomplete = commit & last_row & ~(&mask_next);
    len_bad    = commit & (bit_cnt_reg != BIT_CNT_FULL);

    // Working buffer with the committing row merged in, so row 7 publishes its new data.
    red_next   = red_w_reg;
    green_next = green_w_reg;
    blue_next  = blue_w_reg;
    red_next[sel_info.row]   = hold_reg[RED_MSB:RED_LSB];
    green_next[sel_info.row] = hold_reg[GRN_MSB:GRN_LSB];
    blue_next[sel_info.row]  = hold_reg[BLU_MSB:BLU_LSB];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_reg       <= '0;
      hold_reg        <= '0;
      bit_cnt_reg     <= '0;
      row_mask_reg    <= '0;
      red_w_reg       <= '0;
      green_w_reg     <= '0;
      blue_w_reg      <= '0;
      red_reg         <= '0;
      green_reg       <= '0;
      blue_reg        <= '0;
      row_valid_reg   <= 1'b0;
      frame_valid_reg <= 1'b0;
      row_idx_reg     <= '0;
      len_err_reg     <= 1'b0;
      katot_err_reg   <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      if (!mr_level) begin
        shreg_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (sh_rise) begin
        shreg_reg <= {ds_sync, shreg_reg[WORD_W-1:1]};
        if (bit_cnt_reg != BIT_CNT_MAX) begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      // Non-blocking read of shreg gives the pre-shift value on simultaneous edges.
      if (st_rise) begin
        hold_reg <= shreg_reg;
      end

      row_valid_reg   <= commit;
      frame_valid_reg <= publish;

      if (commit) begin
        red_w_reg    <= red_next;
        green_w_reg  <= green_next;
        blue_w_reg   <= blue_next;
        row_idx_reg  <= sel_info.row;
        row_mask_reg <= last_row ? '0 : mask_next;
      end

      if (publish) begin
        red_reg   <= red_next;
        green_reg <= green_next;
        blue_reg  <= blue_next;
      end

      len_err_reg   <= len_bad    | (len_err_reg   & ~err_clr);
      katot_err_reg <= bad_sel    | (katot_err_reg & ~err_clr);
      frame_err_reg <= incomplete | (frame_err_reg & ~err_clr);
    end
  end

  assign red         = red_reg;
  assign green       = green_reg;
  assign blue        = blue_reg;
  assign row_valid   = row_valid_reg;
  assign row_idx     = row_idx_reg;
  assign frame_valid = frame_valid_reg;
  assign len_err     = len_err_reg;
  assign katot_err   = katot_err_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_rgb_matrix_capture.sv
// Randomised pin-level bench for rgb_matrix_capture with a transaction-level reference model.
module tb_rgb_matrix_capture;
  import rgb_matrix_pkg::*;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, DS, SH_CP, ST_CP, MR_N, OE, err_clr;
  logic [7:0] KATOT;
  plane_t     red, green, blue;
  logic       row_valid, frame_valid, len_err, katot_err, frame_err;
  logic [2:0] row_idx;

  rgb_matrix_capture #(.SYNC_STAGES(SYNC), .WORD_W(24)) dut (
    .clk(clk), .reset(reset), .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP),
    .MR_N(MR_N), .OE(OE), .KATOT(KATOT), .err_clr(err_clr),
    .red(red), .green(green), .blue(blue), .row_valid(row_valid),
    .row_idx(row_idx), .frame_valid(frame_valid), .len_err(len_err),
    .katot_err(katot_err), .frame_err(frame_err)
  );

  typedef struct packed {
    plane_t     red;
    plane_t     green;
    plane_t     blue;
    logic [2:0] ridx;
    logic       rv;
    logic       fv;
    logic       lerr;
    logic       kerr;
    logic       ferr;
  } exp_t;

  int   total = 0, bad = 0, cyc = 0;
  int   fv_count = 0, rv_count = 0;
  bit   cmp_en = 1'b0;
  exp_t m_last, exp_now;
  int   q_cyc[$];
  exp_t q_st[$];

  // Model of what the driver has put on the wire since the last MR_N pulse.
  logic        m_bits[$];
  int          m_cnt;
  logic [23:0] m_hold;
  row_t        w_r[8], w_g[8], w_b[8];
  logic [7:0]  m_seen;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
        exp_now = q_st.pop_front();
        void'(q_cyc.pop_front());
      end else begin
        exp_now.rv = 1'b0;
        exp_now.fv = 1'b0;
      end
      chk("red", 192'(red), 192'(exp_now.red));
      chk("green", 192'(green), 192'(exp_now.green));
      chk("blue", 192'(blue), 192'(exp_now.blue));
      chk("row_valid", 192'(row_valid), 192'(exp_now.rv));
      chk("row_idx", 192'(row_idx), 192'(exp_now.ridx));
      chk("frame_valid", 192'(frame_valid), 192'(exp_now.fv));
      chk("len_err", 192'(len_err), 192'(exp_now.lerr));
      chk("katot_err", 192'(katot_err), 192'(exp_now.kerr));
      chk("frame_err", 192'(frame_err), 192'(exp_now.ferr));
      if (frame_valid) fv_count++;
      if (row_valid) rv_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sched(input int when);
    q_cyc.push_back(when);
    q_st.push_back(m_last);
    m_last.rv = 1'b0;
    m_last.fv = 1'b0;
  endtask

  // Shift register contents: newest bit at position 23, older bits below it.
  function automatic logic [23:0] m_shreg();
    logic [23:0] v = '0;
    for (int a = 0; a < m_bits.size() && a < 24; a++) v[23-a] = m_bits[a];
    return v;
  endfunction

  function automatic void m_push(input logic b);
    m_bits.push_front(b);
    if (m_bits.size() > 32) void'(m_bits.pop_back());
    m_cnt++;
  endfunction

  task automatic shift_bit(input logic b);
    DS = b;
    step(1);
    SH_CP = 1'b1;
    m_push(b);
    step(2);
    SH_CP = 1'b0;
    step(2);
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[i]);
  endtask

  task automatic latch();
    KATOT = 8'($urandom);
    ST_CP = 1'b1;
    m_hold = m_shreg();
    step(2);
    ST_CP = 1'b0;
    step(2);
  endtask

  task automatic shift_latch(input logic b);
    DS = b;
    step(1);
    m_hold = m_shreg();
    m_push(b);
    SH_CP = 1'b1;
    ST_CP = 1'b1;
    step(2);
    SH_CP = 1'b0;
    ST_CP = 1'b0;
    step(2);
  endtask

  task automatic mr_pulse();
    MR_N = 1'b0;
    m_bits.delete();
    m_cnt = 0;
    step(3);
    MR_N = 1'b1;
    step(3);
  endtask

  task automatic mr_shift();
    DS = 1'b1;
    step(1);
    MR_N = 1'b0;
    SH_CP = 1'b1;
    m_bits.delete();
    m_cnt = 0;
    step(2);
    SH_CP = 1'b0;
    step(2);
    MR_N = 1'b1;
    step(3);
  endtask

  task automatic commit(input logic [7:0] k, input bit clr_same);
    int at, n, r;
    KATOT = k;
    step(3);
    OE = 1'b0;
    at = cyc;
    n = 0;
    r = 0;
    for (int i = 0; i < 8; i++) if (k[i]) begin n++; r = 7 - i; end
    if (clr_same) begin
      m_last.lerr = 1'b0;
      m_last.kerr = 1'b0;
      m_last.ferr = 1'b0;
    end
    if (n != 1) begin
      m_last.kerr = 1'b1;
    end else begin
      w_r[r] = m_hold[23:16];
      w_g[r] = m_hold[15:8];
      w_b[r] = m_hold[7:0];
      m_seen[r] = 1'b1;
      m_last.ridx = 3'(r);
      m_last.rv = 1'b1;
      if (m_cnt != 24) m_last.lerr = 1'b1;
      if (r == 7) begin
        if (m_seen == 8'hFF) begin
          for (int j = 0; j < 8; j++) begin
            m_last.red[j] = w_r[j];
            m_last.green[j] = w_g[j];
            m_last.blue[j] = w_b[j];
          end
          m_last.fv = 1'b1;
        end else begin
          m_last.ferr = 1'b1;
        end
        m_seen = '0;
      end
    end
    sched(at + LAT);
    if (clr_same) begin
      step(2);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      step(1);
    end else begin
      step(4);
    end
    OE = 1'b1;
    step(3);
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    m_last.lerr = 1'b0;
    m_last.kerr = 1'b0;
    m_last.ferr = 1'b0;
    sched(cyc + 1);
    step(1);
    err_clr = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_last = '0;
    m_bits.delete();
    m_cnt = 0;
    m_hold = '0;
    m_seen = '0;
    for (int j = 0; j < 8; j++) begin
      w_r[j] = '0;
      w_g[j] = '0;
      w_b[j] = '0;
    end
    sched(cyc + 1);
    step(4);
    reset = 1'b1;
    step(4);
  endtask

  task automatic send_row(input int r, input logic [23:0] w);
    mr_pulse();
    shift_word(32'(w), 24);
    latch();
    commit(8'h80 >> r, 1'b0);
  endtask

  int          fv0, rv0, n, reps;
  logic [7:0]  k;
  logic [23:0] w;

  initial begin
    reset = 1'b0; DS = 1'b0; SH_CP = 1'b0; ST_CP = 1'b0; MR_N = 1'b1;
    OE = 1'b1; KATOT = 8'h00; err_clr = 1'b0;
    m_last = '0; exp_now = '0; m_hold = '0; m_seen = '0; m_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      w_r[j] = '0; w_g[j] = '0; w_b[j] = '0;
    end
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    step(3);
    reset = 1'b1;
    step(5);
    chk("reset_blue", 192'(blue), 192'(0));
    chk("reset_flags", 192'({len_err, katot_err, frame_err}), 192'(0));

    // Single row 0
    rv0 = rv_count;
    send_row(0, 24'h0000A5);
    chk("single_row_idx", 192'(row_idx), 192'(0));
    chk("single_len_err", 192'(len_err), 192'(0));
    chk("single_blue", 192'(blue), 192'(0));
    chk("single_rv_pulses", 192'(rv_count - rv0), 192'(1));

    // Full frame
    fv0 = fv_count;
    for (int r = 0; r < 8; r++) send_row(r, {8'(8'h10 + r), 8'(8'h20 + r), 8'(8'h01 << r)});
    chk("frame_fv_pulses", 192'(fv_count - fv0), 192'(1));
    chk("frame_blue3", 192'(blue[3]), 192'(8'h08));
    chk("frame_red7", 192'(red[7]), 192'(8'h17));
    chk("frame_green0", 192'(green[0]), 192'(8'h20));

    // Short word still commits, flags len_err
    mr_pulse();
    shift_word(32'h00ABCDEF, 20);
    latch();
    commit(8'h80 >> 2, 1'b0);
    chk("short_len_err", 192'(len_err), 192'(1));
    err_clear();
    chk("short_len_clr", 192'(len_err), 192'(0));

    // Bad row select
    rv0 = rv_count;
    mr_pulse();
    shift_word(32'h00123456, 24);
    latch();
    commit(8'h81, 1'b0);
    chk("badsel_katot_err", 192'(katot_err), 192'(1));
    chk("badsel_no_rv", 192'(rv_count - rv0), 192'(0));
    err_clear();

    // Missing row 6
    fv0 = fv_count;
    for (int r = 0; r < 6; r++) send_row(r, 24'h555555);
    send_row(7, 24'hAAAAAA);
    chk("missing_frame_err", 192'(frame_err), 192'(1));
    chk("missing_no_fv", 192'(fv_count - fv0), 192'(0));
    chk("missing_red7_kept", 192'(red[7]), 192'(8'h17));
    err_clear();
    for (int r = 0; r < 8; r++) send_row(r, {8'(8'h30 + r), 8'(8'h40 + r), 8'(~(8'h01 << r))});
    chk("recover_fv_pulses", 192'(fv_count - fv0), 192'(1));
    chk("recover_red7", 192'(red[7]), 192'(8'h37));

    // Simultaneous SH/ST edges (row 3) and MR_N low with SH rise (row 5)
    for (int r = 0; r < 8; r++) begin
      if (r == 3) begin
        mr_pulse();
        shift_word(32'h00123456, 23);
        shift_latch(1'b0);
        commit(8'h80 >> 3, 1'b0);
      end else if (r == 5) begin
        mr_pulse();
        shift_word(32'h3FF, 10);
        mr_shift();
        shift_word(32'h00C3C3C3, 24);
        latch();
        commit(8'h80 >> 5, 1'b0);
      end else begin
        send_row(r, 24'h0F0F0F);
      end
    end
    chk("simul_red3", 192'(red[3]), 192'(8'h24));
    chk("simul_green3", 192'(green[3]), 192'(8'h68));
    chk("simul_blue3", 192'(blue[3]), 192'(8'hAC));
    chk("mrshift_len_err", 192'(len_err), 192'(0));
    chk("mrshift_blue5", 192'(blue[5]), 192'(8'hC3));

    // Reset mid-frame
    for (int r = 0; r < 5; r++) send_row(r, 24'h777777);
    do_reset();
    chk("rst_red", 192'(red), 192'(0));
    chk("rst_row_idx", 192'(row_idx), 192'(0));
    fv0 = fv_count;
    for (int r = 0; r < 8; r++) send_row(r, 24'h010203);
    chk("rst_fv_pulses", 192'(fv_count - fv0), 192'(1));
    chk("rst_blue0", 192'(blue[0]), 192'(8'h03));

    // Randomised frames
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int r = 0; r < 8; r++) begin
        if (r != 7 && $urandom_range(0, 9) == 0) continue;
        reps = (r != 7 && $urandom_range(0, 7) == 0) ? 2 : 1;
        repeat (reps) begin
          if ($urandom_range(0, 7) != 0) mr_pulse();
          n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(18, 30)) : 24;
          shift_word($urandom, n);
          latch();
          if ($urandom_range(0, 11) == 0) begin
            do k = 8'($urandom); while ($countones(k) == 1);
          end else begin
            k = 8'h80 >> r;
          end
          commit(k, $urandom_range(0, 5) == 0);
        end
        if ($urandom_range(0, 7) == 0) err_clear();
      end
    end

    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
